// File: rtl/bus_decoder_n.sv
// bus_decoder_n: base/mask bus decoder with per-transaction slave lock, timeout and error logging
module bus_decoder_n #(
  parameter int NSLV = 3,
  parameter int ADDR_W = 22,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {22'h3FFFF0, 22'h3FF800, 22'h000000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {22'h3FFFF0, 22'h3FFE00, 22'h3C0000},
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_stb,
  input  logic                 bus_we,
  input  logic [ADDR_W-1:0]    bus_addr,
  input  logic [31:0]          bus_dout,
  output logic [31:0]          bus_din,
  output logic                 bus_ack,
  output logic                 bus_err,
  output logic [NSLV-1:0]      slv_stb,
  output logic                 slv_we,
  output logic [ADDR_W-1:0]    slv_addr,
  output logic [31:0]          slv_dout,
  input  logic [NSLV*32-1:0]   slv_din,
  input  logic [NSLV-1:0]      slv_ack,
  output logic [7:0]           err_cnt,
  output logic [ADDR_W-1:0]    err_addr
);
  localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t r_state;
  logic [SW-1:0] r_sel, w_idx;
  logic [15:0] r_tcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] w_din [NSLV];
  logic w_hit, w_busy, w_done, w_tout;
  // descending scan so the lowest matching window is the one left standing
  always_comb begin
    w_idx = '0;
    w_hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--)
      if ((bus_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        w_idx = SW'(i);
        w_hit = 1'b1;
      end
  end
  for (genvar j = 0; j < NSLV; j++) begin : g_din
    assign w_din[j] = slv_din[32*j +: 32];
  end
  assign w_busy   = r_state == BUSY;
  assign w_done   = w_busy && bus_stb && slv_ack[r_sel];
  assign w_tout   = w_busy && bus_stb && !slv_ack[r_sel] && r_tcnt == 16'(TIMEOUT - 1);
  assign slv_stb  = w_busy ? NSLV'(1) << r_sel : '0;
  assign bus_ack  = r_state == ERR || w_done || w_tout;
  assign bus_err  = r_state == ERR || w_tout;
  assign bus_din  = w_busy && !w_tout ? w_din[r_sel] : '0;
  assign slv_we   = bus_we;
  assign slv_addr = bus_addr;
  assign slv_dout = bus_dout;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_tcnt   <= '0;
      r_addr   <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus_stb) begin
          r_state <= w_hit ? BUSY : ERR;
          r_sel   <= w_idx;
          r_addr  <= bus_addr;
          r_tcnt  <= '0;
        end
        BUSY: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (!bus_stb || w_done || w_tout) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (bus_err) begin
        err_addr <= r_addr;
        err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
      end
    end
  end
endmodule
